// File: rtl/mem_port_arbiter_if.sv
// Signal bundle linking the IF/MEM pipeline stages, the port arbiter and the shared memory.
// The master modport is the arbiter's view; slave is the view of the stages plus the memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;

  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency 64-bit memory port between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for alternating grants under contention; default is data-over-fetch.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.master bus
);

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;

  logic          gnt_dm;
  logic          lat_we;
  logic          lat_hi;
  logic [CW-1:0] cnt;

  logic          mem_en_q;
  logic          mem_we_q;
  logic [63:0]   mem_addr_q;
  logic [63:0]   mem_wdata_q;
  logic          if_valid_q;
  logic [31:0]   if_rdata_q;
  logic          dm_valid_q;
  logic [63:0]   dm_rdata_q;

  logic          pick_dm;
  logic          grant;
  logic          capture;
  logic [63:0]   sel_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // gnt_dm doubles as the last-grant memory, so after reset the first contention goes to data
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    capture    = 1'b0;
    pick_dm    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    pick_dm    = bus.dm_req & (~bus.if_req | ~gnt_dm);
`else
    pick_dm    = bus.dm_req;
`endif
    sel_addr   = pick_dm ? bus.dm_addr : bus.if_addr;

    case (state)
      IDLE: begin
        if (bus.dm_req | bus.if_req) begin
          grant      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_dm      <= 1'b0;
      lat_we      <= 1'b0;
      lat_hi      <= 1'b0;
      cnt         <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      mem_en_q   <= grant;
      mem_we_q   <= grant & pick_dm & bus.dm_we;
      if_valid_q <= capture & ~gnt_dm;
      dm_valid_q <= capture & gnt_dm;

      if (grant) begin
        gnt_dm     <= pick_dm;
        lat_we     <= pick_dm & bus.dm_we;
        lat_hi     <= bus.if_addr[2];
        mem_addr_q <= sel_addr & ~64'h7;
        if (pick_dm) begin
          mem_wdata_q <= bus.dm_wdata;
        end
      end

      if (state == ISSUE) begin
        cnt <= CW'(MEM_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end

      // A store completes without touching the load-data register
      if (capture) begin
        if (gnt_dm) begin
          if (!lat_we) begin
            dm_rdata_q <= bus.mem_rdata;
          end
        end else begin
          if_rdata_q <= lat_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
        end
      end
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2: per-cycle vector table plus hand sequences.
// The memory model returns real data only in the cycle the latency says it is valid.
module tb_mem_port_arbiter;

  localparam logic [63:0] MEM_DATA = 64'hAAAABBBB_CCCCDDDD;
  localparam logic [63:0] JUNK     = 64'hDEADBEEF_0BADF00D;
  localparam logic [31:0] HI       = 32'hAAAABBBB;
  localparam logic [31:0] LO       = 32'hCCCCDDDD;
  localparam int          NV       = 24;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        if_valid;
    logic        if_stall;
    logic [31:0] if_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic [63:0] dm_rdata;
  } vec_t;

  logic clk;
  logic reset;
  logic en_d1 = 1'b0;
  logic en_d2 = 1'b0;
  int   checks = 0;
  int   fails = 0;
  vec_t vecs [NV];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is only meaningful two cycles after the enable cycle
  always @(posedge clk) begin
    en_d1 <= bus.mem_en;
    en_d2 <= en_d1;
  end
  assign bus.mem_rdata = en_d2 ? MEM_DATA : JUNK;

  function automatic vec_t mk(
    logic rst, logic ir, logic [63:0] ia, logic dr, logic dw, logic [63:0] da, logic [63:0] dwd,
    logic me, logic mw, logic [63:0] ma, logic [63:0] mwd,
    logic iv, logic is, logic [31:0] ird, logic dv, logic ds, logic [63:0] drd);
    vec_t v;
    v.rst = rst;       v.if_req = ir;    v.if_addr = ia;
    v.dm_req = dr;     v.dm_we = dw;     v.dm_addr = da;     v.dm_wdata = dwd;
    v.mem_en = me;     v.mem_we = mw;    v.mem_addr = ma;    v.mem_wdata = mwd;
    v.if_valid = iv;   v.if_stall = is;  v.if_rdata = ird;
    v.dm_valid = dv;   v.dm_stall = ds;  v.dm_rdata = drd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveIdle();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".mem_en"},    64'(bus.mem_en),    64'd0);
    checkOutput({tag, ".mem_we"},    64'(bus.mem_we),    64'd0);
    checkOutput({tag, ".mem_addr"},  bus.mem_addr,       64'd0);
    checkOutput({tag, ".mem_wdata"}, bus.mem_wdata,      64'd0);
    checkOutput({tag, ".if_valid"},  64'(bus.if_valid),  64'd0);
    checkOutput({tag, ".if_stall"},  64'(bus.if_stall),  64'd0);
    checkOutput({tag, ".if_rdata"},  64'(bus.if_rdata),  64'd0);
    checkOutput({tag, ".dm_valid"},  64'(bus.dm_valid),  64'd0);
    checkOutput({tag, ".dm_stall"},  64'(bus.dm_stall),  64'd0);
    checkOutput({tag, ".dm_rdata"},  bus.dm_rdata,       64'd0);
  endtask

  // Leaves the caller at the start of a fresh cycle with the arbiter idle
  task automatic doReset();
    driveIdle();
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rst) doReset();
    bus.if_req   = v.if_req;
    bus.if_addr  = v.if_addr;
    bus.dm_req   = v.dm_req;
    bus.dm_we    = v.dm_we;
    bus.dm_addr  = v.dm_addr;
    bus.dm_wdata = v.dm_wdata;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    checkOutput({t, ".mem_en"},    64'(bus.mem_en),   64'(v.mem_en));
    checkOutput({t, ".mem_we"},    64'(bus.mem_we),   64'(v.mem_we));
    checkOutput({t, ".mem_addr"},  bus.mem_addr,      v.mem_addr);
    checkOutput({t, ".mem_wdata"}, bus.mem_wdata,     v.mem_wdata);
    checkOutput({t, ".if_valid"},  64'(bus.if_valid), 64'(v.if_valid));
    checkOutput({t, ".if_stall"},  64'(bus.if_stall), 64'(v.if_stall));
    checkOutput({t, ".if_rdata"},  64'(bus.if_rdata), 64'(v.if_rdata));
    checkOutput({t, ".dm_valid"},  64'(bus.dm_valid), 64'(v.dm_valid));
    checkOutput({t, ".dm_stall"},  64'(bus.dm_stall), 64'(v.dm_stall));
    checkOutput({t, ".dm_rdata"},  bus.dm_rdata,      v.dm_rdata);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Fetch only at 0x4: enable in cycle 1, upper word returned with the pulse in cycle 4
    vecs[0]  = mk(1, 1, 64'h4, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 1, 32'h0, 0, 0, 64'h0);
    vecs[1]  = mk(0, 1, 64'h4, 0, 0, 64'h0, 64'h0, 1, 0, 64'h0, 64'h0, 0, 1, 32'h0, 0, 0, 64'h0);
    vecs[2]  = mk(0, 1, 64'h4, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 1, 32'h0, 0, 0, 64'h0);
    vecs[3]  = mk(0, 1, 64'h4, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 1, 32'h0, 0, 0, 64'h0);
    vecs[4]  = mk(0, 1, 64'h4, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 1, 0, HI,    0, 0, 64'h0);
    vecs[5]  = mk(0, 0, 64'h4, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 0, HI,    0, 0, 64'h0);
    vecs[6]  = mk(0, 0, 64'h4, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 0, HI,    0, 0, 64'h0);
    // Contention: load at 0x8 served first, fetch at 0x0 follows and completes in cycle 9
    vecs[7]  = mk(1, 1, 64'h0, 1, 0, 64'h8, 64'h0, 0, 0, 64'h0, 64'h0, 0, 1, 32'h0, 0, 1, 64'h0);
    vecs[8]  = mk(0, 1, 64'h0, 1, 0, 64'h8, 64'h0, 1, 0, 64'h8, 64'h0, 0, 1, 32'h0, 0, 1, 64'h0);
    vecs[9]  = mk(0, 1, 64'h0, 1, 0, 64'h8, 64'h0, 0, 0, 64'h8, 64'h0, 0, 1, 32'h0, 0, 1, 64'h0);
    vecs[10] = mk(0, 1, 64'h0, 1, 0, 64'h8, 64'h0, 0, 0, 64'h8, 64'h0, 0, 1, 32'h0, 0, 1, 64'h0);
    vecs[11] = mk(0, 1, 64'h0, 1, 0, 64'h8, 64'h0, 0, 0, 64'h8, 64'h0, 0, 1, 32'h0, 1, 0, MEM_DATA);
    vecs[12] = mk(0, 1, 64'h0, 0, 0, 64'h8, 64'h0, 0, 0, 64'h8, 64'h0, 0, 1, 32'h0, 0, 0, MEM_DATA);
    vecs[13] = mk(0, 1, 64'h0, 0, 0, 64'h8, 64'h0, 1, 0, 64'h0, 64'h0, 0, 1, 32'h0, 0, 0, MEM_DATA);
    vecs[14] = mk(0, 1, 64'h0, 0, 0, 64'h8, 64'h0, 0, 0, 64'h0, 64'h0, 0, 1, 32'h0, 0, 0, MEM_DATA);
    vecs[15] = mk(0, 1, 64'h0, 0, 0, 64'h8, 64'h0, 0, 0, 64'h0, 64'h0, 0, 1, 32'h0, 0, 0, MEM_DATA);
    vecs[16] = mk(0, 1, 64'h0, 0, 0, 64'h8, 64'h0, 0, 0, 64'h0, 64'h0, 1, 0, LO,    0, 0, MEM_DATA);
    vecs[17] = mk(0, 0, 64'h0, 0, 0, 64'h8, 64'h0, 0, 0, 64'h0, 64'h0, 0, 0, LO,    0, 0, MEM_DATA);
    // Store at 0x13 straight after: address aligned down, load data left untouched
    vecs[18] = mk(0, 0, 64'h0, 1, 1, 64'h13, 64'h1234, 0, 0, 64'h0,  64'h0,    0, 0, LO, 0, 1, MEM_DATA);
    vecs[19] = mk(0, 0, 64'h0, 1, 1, 64'h13, 64'h1234, 1, 1, 64'h10, 64'h1234, 0, 0, LO, 0, 1, MEM_DATA);
    vecs[20] = mk(0, 0, 64'h0, 1, 1, 64'h13, 64'h1234, 0, 0, 64'h10, 64'h1234, 0, 0, LO, 0, 1, MEM_DATA);
    vecs[21] = mk(0, 0, 64'h0, 1, 1, 64'h13, 64'h1234, 0, 0, 64'h10, 64'h1234, 0, 0, LO, 0, 1, MEM_DATA);
    vecs[22] = mk(0, 0, 64'h0, 1, 1, 64'h13, 64'h1234, 0, 0, 64'h10, 64'h1234, 0, 0, LO, 1, 0, MEM_DATA);
    vecs[23] = mk(0, 0, 64'h0, 0, 0, 64'h13, 64'h1234, 0, 0, 64'h10, 64'h1234, 0, 0, LO, 0, 0, MEM_DATA);

    reset = 1'b1;
    driveIdle();

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
      nextCycle();
    end

    // Reset during cycle 2 of a fetch to 0xC: everything clears and the late read data is ignored
    doReset();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'hC;
    nextCycle();
    @(negedge clk);
    checkOutput("t4.mem_en_c1",   64'(bus.mem_en), 64'd1);
    checkOutput("t4.mem_addr_c1", bus.mem_addr,    64'h8);
    nextCycle();
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    #1;
    checkAllZero("t4.mid");
    #2;
    reset = 1'b0;
    nextCycle();
    @(negedge clk);
    checkOutput("t4.if_valid_c3", 64'(bus.if_valid), 64'd0);
    checkOutput("t4.if_rdata_c3", 64'(bus.if_rdata), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4.if_valid_c4", 64'(bus.if_valid), 64'd0);
    checkOutput("t4.if_rdata_c4", 64'(bus.if_rdata), 64'd0);
    nextCycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h0;
    for (int c = 0; c < 3; c++) nextCycle();
    @(negedge clk);
    checkOutput("t4.if_valid_early", 64'(bus.if_valid), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4.if_valid", 64'(bus.if_valid), 64'd1);
    checkOutput("t4.if_rdata", 64'(bus.if_rdata), 64'(LO));
    nextCycle();
    driveIdle();

    // Both requests held continuously: data always wins unless round robin alternates
    doReset();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h4;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 64'h8;
    for (int k = 0; k < 4; k++) begin
      int   waited;
      logic got_if;
      logic got_dm;
      logic exp_dm;
      waited = 0;
      got_if = 1'b0;
      got_dm = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_dm = (k % 2) == 0;
`else
      exp_dm = 1'b1;
`endif
      while (!got_if && !got_dm && waited < 12) begin
        @(negedge clk);
        got_if = bus.if_valid;
        got_dm = bus.dm_valid;
        if (!got_if && !got_dm) begin
          nextCycle();
          waited++;
        end
      end
      checkOutput($sformatf("t5.latency%0d", k), 64'(waited), 64'd4);
      checkOutput($sformatf("t5.dm_grant%0d", k), 64'(got_dm), 64'(exp_dm));
      checkOutput($sformatf("t5.if_grant%0d", k), 64'(got_if), 64'(!exp_dm));
      checkOutput($sformatf("t5.if_stall%0d", k), 64'(bus.if_stall), 64'(exp_dm));
      nextCycle();
    end
    driveIdle();

    // Fetch dropped in cycle 2 still completes; a re-request is not granted until IDLE
    doReset();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h4;
    nextCycle();
    @(negedge clk);
    checkOutput("t6.mem_en_c1", 64'(bus.mem_en), 64'd1);
    nextCycle();
    bus.if_req = 1'b0;
    @(negedge clk);
    checkOutput("t6.if_stall_c2", 64'(bus.if_stall), 64'd0);
    nextCycle();
    bus.if_req = 1'b1;
    @(negedge clk);
    checkOutput("t6.mem_en_c3", 64'(bus.mem_en), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t6.if_valid_c4", 64'(bus.if_valid), 64'd1);
    checkOutput("t6.if_rdata_c4", 64'(bus.if_rdata), 64'(HI));
    checkOutput("t6.mem_en_c4",   64'(bus.mem_en),   64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t6.mem_en_c5",   64'(bus.mem_en),   64'd0);
    checkOutput("t6.if_stall_c5", 64'(bus.if_stall), 64'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t6.mem_en_c6", 64'(bus.mem_en), 64'd1);
    nextCycle();
    driveIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
